key_add_flag: RTL
=================

# key_add_flag

Debounces one raw mechanical push-button and converts each accepted press into a single-cycle increment pulse. It sits directly upstream of the static seven-segment digit driver, in place of or alongside the free-running timer. Its `flag` output drives that driver's `add_flag` input, so the displayed digit advances once per press. With auto-repeat compiled in, the digit also keeps advancing while the button is held.

## Interface
- `DEBOUNCE_CNT`, default 25'd1_000_000: stable-level time in clk cycles (20 ms at 50 MHz). Legal range ≥ 2.
- `REPEAT_DELAY`, default 25'd25_000_000: hold time before the first auto-repeat pulse (500 ms). Legal range ≥ 2.
- `REPEAT_PERIOD`, default 25'd5_000_000: spacing of later auto-repeat pulses (100 ms). Legal range ≥ 2.
- `clk`, input, 1: system clock (50 MHz).
- `rst`, input, 1: reset, synchronous and active-high.
- `key_n`, input, 1: raw button, active-low, asynchronous to clk.
- `flag`, output, 1: registered single-cycle increment pulse; connects to the digit driver's `add_flag`.
- `key_state`, output, 1: registered debounced level, 1 = pressed.

## Operation
- **Synchronizer:** `key_n` passes through a 2-flop synchronizer, giving `key_s`. Both flops reset to 1 (released).
- **Counters:** one 25-bit debounce counter `db_cnt`; one 25-bit repeat counter `rep_cnt`.
- **FSM states:** IDLE, PRESS_DB, HELD, RELEASE_DB. Reset state is IDLE.
- **IDLE:**
  - `key_s`=0 → PRESS_DB, with `db_cnt`←0.
- **PRESS_DB:**
  - `key_s`=1 → IDLE, with `db_cnt`←0 (glitch rejected, no flag).
  - Otherwise `db_cnt` increments.
  - At `db_cnt`==DEBOUNCE_CNT-1 → HELD; assert `flag` for one cycle; `key_state`←1; `rep_cnt`←0.
- **HELD:**
  - `key_s`=1 → RELEASE_DB, with `db_cnt`←0.
  - Auto-repeat runs only in this state (see Configuration).
- **RELEASE_DB:**
  - `key_s`=0 → HELD, with `rep_cnt`←0 and no flag (release bounce absorbed).
  - Otherwise `db_cnt` increments.
  - At `db_cnt`==DEBOUNCE_CNT-1 → IDLE; `key_state`←0.
- **Flag width:** `flag` is never high for two consecutive cycles.
- **Counter overflow:** counters never wrap, because every compare terminates the count first.
- **Simultaneous events:** a `key_s` change in the same cycle as a terminal count is resolved by the level check, which wins. No flag, no transition on the count.
- **Reset mid-operation:** `rst` high for one edge sets, from the next cycle:
  - FSM = IDLE;
  - both counters = 0;
  - `flag`=0, `key_state`=0;
  - synchronizer = 1.
  
  A key still held after reset must be re-debounced from scratch, producing one new flag.

## Timing
- **Reset values:** `flag`=0, `key_state`=0.
- **Press latency:** with `key_n` low and stable, `flag` is high during the cycle after edge DEBOUNCE_CNT+3, counting edge 1 as the first rising edge that samples `key_n`=0. This is 2 synchronizer edges + 1 IDLE→PRESS_DB edge + DEBOUNCE_CNT count edges.
- **Pressed level:** `key_state` rises on the same edge as `flag`.
- **Release latency:** `key_state` falls DEBOUNCE_CNT+3 edges after the first edge that samples `key_n`=1.
- **Auto-repeat timing:**
  - First repeat `flag` comes REPEAT_DELAY cycles after the press flag.
  - Each later one comes REPEAT_PERIOD cycles after the previous one.
- **Downstream handshake:** none. The consumer samples `flag` every cycle and must accept back-to-back pulses spaced ≥ 2 cycles apart.

## Configuration
- **Macro:** `KEY_AUTO_REPEAT_EN`.
- **Defined:** in HELD, `rep_cnt` increments every cycle.
  - On the first terminal count (REPEAT_DELAY-1), assert `flag` for one cycle and set `rep_cnt`←0, with the period now REPEAT_PERIOD.
  - On each later terminal count (REPEAT_PERIOD-1), assert `flag` for one cycle and set `rep_cnt`←0.
  - Leaving HELD cancels the repeat sequence. Re-entering HELD from RELEASE_DB restarts it with REPEAT_DELAY.
- **Undefined:** `rep_cnt` and the repeat logic are absent; exactly one `flag` per debounced press.

## Structure
- **Package `seg_led_pkg`:**
  - state enum typedef `key_state_t` (IDLE, PRESS_DB, HELD, RELEASE_DB);
  - constant `CNT_W = 25`;
  - default timing constants expressed as time/20 ns.
- **Sub-module `key_sync`:** the 2-flop synchronizer, parameterised reset value 1. Instantiated once.
- **Top-level integration:** this block sits in the display top next to the timer. The two flag sources are ORed into `add_flag` by the top, not by this block.

## Test plan
All scenarios use DEBOUNCE_CNT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- **Clean press:** `key_n` driven low and held → one `flag` pulse in the cycle after edge 7; `key_state` rises on the same edge.
- **Glitch:** `key_n` low for 4 edges, then high → no `flag`; `key_state` stays 0; FSM returns to IDLE.
- **Release bounce:** while held, `key_n` high for 2 edges, then low → no extra `flag`; `key_state` stays 1.
- **Auto-repeat, macro defined:** hold for 30 edges after the first flag → flags at +10, +13, +16, +19, +22, +25, +28. Without the macro → exactly 1 flag.
- **Reset mid-press:** `rst` asserted at PRESS_DB count 2 with `key_n` still low → the next cycle shows `flag`=0 and `key_state`=0, then a fresh flag 7 edges after `rst` deasserts.

Source files
------------

// File: rtl/seg_led_pkg.sv
// Shared types and default timing for the seven-segment display slice.
package seg_led_pkg;

    localparam int unsigned CNT_W         = 25;
    localparam int unsigned CLK_PERIOD_NS = 20;

    // Default timings written as duration in ns divided by the 20 ns clock period.
    localparam logic [CNT_W-1:0] DEBOUNCE_CNT_DEF  = CNT_W'(20_000_000  / CLK_PERIOD_NS);
    localparam logic [CNT_W-1:0] REPEAT_DELAY_DEF  = CNT_W'(500_000_000 / CLK_PERIOD_NS);
    localparam logic [CNT_W-1:0] REPEAT_PERIOD_DEF = CNT_W'(100_000_000 / CLK_PERIOD_NS);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } key_state_t;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for a single asynchronous level, reset to RST_VAL.
module key_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_add_flag.sv
// Push-button debouncer emitting one flag pulse per accepted press.
// Define KEY_AUTO_REPEAT_EN to add auto-repeat pulses while the button is held.
module key_add_flag
    import seg_led_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEBOUNCE_CNT  = DEBOUNCE_CNT_DEF,
    parameter logic [CNT_W-1:0] REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter logic [CNT_W-1:0] REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic flag,
    output logic key_state
);

    localparam logic [CNT_W-1:0] DB_LAST = DEBOUNCE_CNT - CNT_W'(1);

    logic             key_s;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             flag_q, flag_d;
    logic             key_state_q, key_state_d;

`ifdef KEY_AUTO_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;
    logic [CNT_W-1:0] rep_last;

    // The first repeat waits the long delay, later ones use the short period.
    assign rep_last = rep_first_q ? (REPEAT_DELAY - CNT_W'(1))
                                  : (REPEAT_PERIOD - CNT_W'(1));
`else
    logic unused_rep_cfg;
    assign unused_rep_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    key_sync #(
        .RST_VAL (1'b1)
    ) u_key_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_n),
        .q   (key_s)
    );

    // Level checks come first in every state so a bounce beats a terminal count.
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        flag_d      = 1'b0;
        key_state_d = key_state_q;
`ifdef KEY_AUTO_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
`endif
        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d  = PRESS_DB;
                    db_cnt_d = '0;
                end
            end
            PRESS_DB: begin
                if (key_s) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = HELD;
                    db_cnt_d    = '0;
                    flag_d      = 1'b1;
                    key_state_d = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
`endif
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (key_s) begin
                    state_d  = RELEASE_DB;
                    db_cnt_d = '0;
                end
`ifdef KEY_AUTO_REPEAT_EN
                else if (rep_cnt_q == rep_last) begin
                    flag_d      = 1'b1;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b0;
                end else begin
                    rep_cnt_d = rep_cnt_q + CNT_W'(1);
                end
`endif
            end
            RELEASE_DB: begin
                if (!key_s) begin
                    state_d  = HELD;
                    db_cnt_d = '0;
`ifdef KEY_AUTO_REPEAT_EN
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
`endif
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = IDLE;
                    db_cnt_d    = '0;
                    key_state_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            flag_q      <= 1'b0;
            key_state_q <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            flag_q      <= flag_d;
            key_state_q <= key_state_d;
`ifdef KEY_AUTO_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    assign flag      = flag_q;
    assign key_state = key_state_q;

endmodule
